triangle_setup: RTL

- Assembles a stream of screen-space vertices into triangles and computes signed area and bounding box.
- Culls degenerate, back-facing (optional) and fully off-screen triangles.
- Reorders surviving triangles into the winding the rasterizer's edge test accepts, then launches it and holds until it reports done.
- Sits directly upstream of the rasterizer: drives its start and six vertex inputs, and watches its done output.

---
 rtl/raster_pkg.sv | 23 ++
 rtl/tri_edge_setup.sv | 46 ++++
 rtl/triangle_setup.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared types and widths for the triangle setup / rasterizer pair.
package raster_pkg;

    localparam int unsigned CORD_WIDTH = 10;
    localparam int unsigned AREA_W     = 2 * CORD_WIDTH + 3;

    typedef logic signed [CORD_WIDTH-1:0] coord_t;
    typedef logic signed [AREA_W-1:0]     area_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        SETUP   = 3'd1,
        LAUNCH  = 3'd2,
        SETTLE  = 3'd3,
        DRAIN   = 3'd4
    } setup_state_e;

endpackage

// File: rtl/tri_edge_setup.sv
// Combinational signed area and bounding box of one triangle.
module tri_edge_setup
    import raster_pkg::*;
(
    input  vertex_t v0,
    input  vertex_t v1,
    input  vertex_t v2,
    output area_t   area_c,
    output coord_t  min_x_c,
    output coord_t  max_x_c,
    output coord_t  min_y_c,
    output coord_t  max_y_c
);

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    area_t d1x, d1y, d2x, d2y;

    // Edge vectors from v0, then the 2D cross product at full width (cannot overflow).
    always_comb begin
        d1x    = area_t'(v1.x) - area_t'(v0.x);
        d1y    = area_t'(v1.y) - area_t'(v0.y);
        d2x    = area_t'(v2.x) - area_t'(v0.x);
        d2y    = area_t'(v2.y) - area_t'(v0.y);
        area_c = (d1x * d2y) - (d1y * d2x);
    end

    // Axis-aligned bounding box.
    always_comb begin
        min_x_c = min3(v0.x, v1.x, v2.x);
        max_x_c = max3(v0.x, v1.x, v2.x);
        min_y_c = min3(v0.y, v1.y, v2.y);
        max_y_c = max3(v0.y, v1.y, v2.y);
    end

endmodule

// File: rtl/triangle_setup.sv
// Vertex assembly, culling, winding fix-up and rasterizer launch handshake.
module triangle_setup
    import raster_pkg::*;
#(
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_vtx_valid,
    output logic                         o_vtx_ready,
    input  logic signed [CORD_WIDTH-1:0] i_vtx_x,
    input  logic signed [CORD_WIDTH-1:0] i_vtx_y,
    input  logic                         i_cull_back,
    input  logic                         i_flush,
    output logic                         o_start,
    output logic signed [CORD_WIDTH-1:0] o_v0_x,
    output logic signed [CORD_WIDTH-1:0] o_v0_y,
    output logic signed [CORD_WIDTH-1:0] o_v1_x,
    output logic signed [CORD_WIDTH-1:0] o_v1_y,
    output logic signed [CORD_WIDTH-1:0] o_v2_x,
    output logic signed [CORD_WIDTH-1:0] o_v2_y,
    input  logic                         i_raster_done,
    output logic                         o_busy,
    output logic [15:0]                  o_tri_count,
    output logic [15:0]                  o_cull_count
);

    localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

    setup_state_e state;
    logic [1:0]   vcnt;
    vertex_t      slot [3];

    area_t  area_c;
    coord_t min_x_c, max_x_c, min_y_c, max_y_c;
    logic   area_zero_c, area_neg_c, cull_c;

    tri_edge_setup u_edge (
        .v0      (slot[0]),
        .v1      (slot[1]),
        .v2      (slot[2]),
        .area_c  (area_c),
        .min_x_c (min_x_c),
        .max_x_c (max_x_c),
        .min_y_c (min_y_c),
        .max_y_c (max_y_c)
    );

    // Cull decision evaluated while in SETUP.
    always_comb begin
        area_zero_c = (area_c == '0);
        area_neg_c  = area_c[AREA_W-1];
        cull_c      = area_zero_c
                    || (area_neg_c && i_cull_back)
                    || max_x_c[CORD_WIDTH-1]
                    || (min_x_c > X_MAX)
                    || max_y_c[CORD_WIDTH-1]
                    || (min_y_c > Y_MAX);
    end

    // Launch pulse follows done combinationally so it lands in the same cycle.
    assign o_start = (state == LAUNCH) && i_raster_done && !i_flush;

    // Setup FSM with vertex slots, output vertex registers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= COLLECT;
            vcnt         <= 2'd0;
            slot[0]      <= '0;
            slot[1]      <= '0;
            slot[2]      <= '0;
            o_vtx_ready  <= 1'b1;
            o_busy       <= 1'b0;
            o_v0_x       <= '0;
            o_v0_y       <= '0;
            o_v1_x       <= '0;
            o_v1_y       <= '0;
            o_v2_x       <= '0;
            o_v2_y       <= '0;
            o_tri_count  <= 16'd0;
            o_cull_count <= 16'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (i_flush) begin
                        vcnt <= 2'd0;
                    end else if (i_vtx_valid) begin
                        slot[vcnt] <= '{x: i_vtx_x, y: i_vtx_y};
                        if (vcnt == 2'd2) begin
                            vcnt        <= 2'd0;
                            state       <= SETUP;
                            o_vtx_ready <= 1'b0;
                            o_busy      <= 1'b1;
                        end else begin
                            vcnt <= vcnt + 2'd1;
                        end
                    end
                end
                SETUP: begin
                    if (i_flush) begin
                        state       <= COLLECT;
                        o_vtx_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end else if (cull_c) begin
                        o_cull_count <= o_cull_count + 16'd1;
                        state        <= COLLECT;
                        o_vtx_ready  <= 1'b1;
                        o_busy       <= 1'b0;
                    end else begin
                        // Positive area is swapped so the rasterizer always sees negative winding.
                        o_v0_x <= slot[0].x;
                        o_v0_y <= slot[0].y;
                        if (area_neg_c) begin
                            o_v1_x <= slot[1].x;
                            o_v1_y <= slot[1].y;
                            o_v2_x <= slot[2].x;
                            o_v2_y <= slot[2].y;
                        end else begin
                            o_v1_x <= slot[2].x;
                            o_v1_y <= slot[2].y;
                            o_v2_x <= slot[1].x;
                            o_v2_y <= slot[1].y;
                        end
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (i_flush) begin
                        state       <= COLLECT;
                        o_vtx_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end else if (o_start) begin
                        o_tri_count <= o_tri_count + 16'd1;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Rasterizer done is stale for one cycle after start.
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (i_raster_done) begin
                        state       <= COLLECT;
                        o_vtx_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: begin
                    state       <= COLLECT;
                    vcnt        <= 2'd0;
                    o_vtx_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
